// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the memory read responder.
package mem_resp_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_LATENCY = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } resp_state_e;

endpackage

// File: rtl/mem_resp_ram.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, so a same-edge
// write never disturbs the word being read (read-before-write).
module mem_resp_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side responder: accepts mem_read, waits LATENCY edges, then loads data_bus
// and pulses data_ready. Optional data_par output under MEM_READ_RESPONDER_PARITY_EN.
module mem_read_responder
   import mem_resp_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              mem_read,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] data_bus,
   output logic              data_ready,
   output logic              busy
`ifdef MEM_READ_RESPONDER_PARITY_EN
   ,
   output logic              data_par
`endif
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(LATENCY);
   // Acceptance out of READY overlaps the pulse cycle, keeping the period at LATENCY.
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   resp_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] bus_q, bus_d;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;
   logic              load;

   mem_resp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en && !reset),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (ram_raddr),
      .rd_data (ram_rdata)
   );

   // With single-cycle latency the word is loaded on the accepting edge itself.
   assign ram_raddr = (LATENCY == 1) ? rd_addr : addr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_read) begin
               addr_d = rd_addr;
               if (LATENCY == 1) begin
                  load    = 1'b1;
                  state_d = ST_READY;
               end else begin
                  cnt_d   = CNT_FULL;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!mem_read) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_ONE) begin
               cnt_d   = '0;
               load    = 1'b1;
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_READY: begin
            if (mem_read) begin
               addr_d = rd_addr;
               if (LATENCY == 1) begin
                  load    = 1'b1;
                  state_d = ST_READY;
               end else begin
                  cnt_d   = CNT_RELOAD;
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      bus_d = load ? ram_rdata : bus_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         bus_q   <= bus_d;
      end
   end

   assign data_bus   = bus_q;
   assign data_ready = (state_q == ST_READY);
   assign busy       = (state_q != ST_IDLE);

`ifdef MEM_READ_RESPONDER_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = load ? ^ram_rdata : par_q;
   end

   always_ff @(posedge clk) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= par_d;
   end

   assign data_par = par_q;
`endif

endmodule
